ibex_instr_aligner: RTL and testbench
=====================================

# ibex_instr_aligner

Sequencer between the instruction fetch buffer and the compressed decoder. It takes word-aligned 32-bit fetch words and extracts one instruction per handshake, which may be 16-bit or 32-bit and may sit at either halfword offset. It tracks the instruction PC, buffers the upper halfword of a word when a 32-bit instruction straddles two fetch words, and handles redirects (flush) and fetch errors. Downstream, `out_instr_o` feeds the compressed decoder's `instr_i`.

## Interface
- `BOOT_ADDR`, default 32'h0000_0080: PC after reset. Bit 0 ignored.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `flush_i` input 1: redirect. Discards all buffered state.
- `flush_addr_i` input 32: redirect target. Bit 0 ignored.
- `fetch_valid_i` input 1: fetch word available.
- `fetch_rdata_i` input 32: word at address `{pc[31:2],2'b00}`.
- `fetch_err_i` input 1: bus error for this word. Qualified by `fetch_valid_i`.
- `fetch_ready_o` output 1: the word is consumed this cycle.
- `out_valid_o` output 1: instruction available.
- `out_ready_i` input 1: downstream accepts.
- `out_instr_o` output 32: raw instruction. A compressed instruction is presented as `{16'h0, hw}`.
- `out_pc_o` output 32: address of the instruction.
- `out_is_compressed_o` output 1: `out_instr_o[1:0] != 2'b11`.
- `out_err_o` output 1: fetch error entry. `out_instr_o` = 0 when set.

## Operation
- Registers: `pc[31:1]`, `buf_hw[15:0]`, `state` ∈ {EMPTY, BUF, HALT}. `buf_hw` holds the halfword at `pc` (so `pc[1]` = 1) of the previous word.
- Let W = `fetch_rdata_i`, out_hs = `out_valid_o & out_ready_i`. All outputs are combinational from the registers and fetch inputs.
- **EMPTY, `pc[1]`=0:**
  - W[1:0]≠11: emit W[15:0]. On out_hs, pc+=2 and `fetch_ready_o`=0, so the word stays.
  - Otherwise: emit W. On out_hs, pc+=4 and `fetch_ready_o`=1.
- **EMPTY, `pc[1]`=1:**
  - W[17:16]≠11: emit W[31:16]. On out_hs, pc+=2 and `fetch_ready_o`=1.
  - Otherwise: `out_valid_o`=0, `fetch_ready_o`=1, `buf_hw`←W[31:16], state→BUF.
- **BUF:** emit `{W[15:0], buf_hw}` with `out_pc_o`=pc. On out_hs, pc+=4, state→EMPTY, and `fetch_ready_o`=0, because W[31:16] is the next instruction.
- Emission in every case requires `fetch_valid_i`. With no valid word, `out_valid_o`=0 and `fetch_ready_o`=0.
- **Error:**
  - If `fetch_err_i` is set with a valid word in EMPTY or BUF, emit `out_err_o`=1, `out_instr_o`=0, `out_pc_o`=pc.
  - On out_hs, `fetch_ready_o`=1 and state→HALT.
  - The error takes priority over the compressed/straddle decision.
- **HALT:** `out_valid_o`=0 and `fetch_ready_o`=1, draining stale words until a flush.
- **Flush** overrides everything in its cycle:
  - `out_valid_o`=0, `fetch_ready_o`=1, and the fetch word is discarded.
  - Next cycle: pc=`{flush_addr_i[31:1]}`, state=EMPTY.
- **PC arithmetic:** pc wraps modulo 2^32. `out_pc_o[0]`=0 always.

## Timing
- Zero-cycle latency from the fetch word to `out_valid_o`. Throughput is one instruction per cycle.
- A straddling 32-bit instruction costs one extra cycle when it is fetched from EMPTY with `pc[1]`=1.
- `fetch_ready_o` depends combinationally on `out_ready_i`. There is no combinational path from `out_ready_i` to `out_valid_o`.
- Stability while `out_valid_o` & !`out_ready_i`:
  - `out_*` stays stable.
  - The upstream buffer must hold its word, since `fetch_ready_o`=0.
- Reset values:
  - Registers: state=EMPTY, pc=BOOT_ADDR, `buf_hw`=0.
  - Outputs: `out_valid_o`=0, `out_err_o`=0, `fetch_ready_o`=0.
  - `out_pc_o`=BOOT_ADDR.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge, and drops any in-flight instruction.
- Simultaneous flush and out_ready: the handshake does not occur and the PC does not advance.

## Test plan
- **32-bit aligned:**
  - Stimulus: after reset, word 0x00000013, out_ready=1.
  - Required: out pc 0x80, instr 0x00000013, compressed=0, fetch_ready=1 in the same cycle.
- **Two compressed in one word:**
  - Stimulus: word 0x45054501.
  - Required first cycle: pc 0x80, instr 0x00004501, compressed=1, fetch_ready=0.
  - Required next cycle: pc 0x82, instr 0x00004505, fetch_ready=1.
- **Straddle:**
  - Stimulus: word0 0x00934501, then word1 0x45050000.
  - Required outputs, in order:
    - pc 0x80, instr 0x00004501.
    - One bubble cycle, with word0 consumed and state BUF.
    - pc 0x82, instr 0x00000093.
    - pc 0x86, instr 0x00004505.
- **Flush to odd halfword:**
  - Stimulus: flush_addr 0x102, then word 0x45050013.
  - Required: the low half is dropped. Out pc 0x102, instr 0x00004505, fetch_ready=1.
- **Backpressure:**
  - Stimulus: out_ready=0 for 3 cycles in BUF.
  - Required: out_instr/out_pc constant and fetch_ready=0 throughout. A single handshake on release.
- **Error and reset:**
  - Stimulus: fetch_err on word1 of a straddle.
  - Required: err entry with pc 0x82. Then out_valid=0 while words drain, until flush_addr 0x200 yields pc 0x200.
  - Stimulus: async rst asserted mid-BUF.
  - Required: out_valid falls before the next clock edge.

Source files
------------

// File: rtl/ibex_instr_aligner.sv
// Instruction aligner: splits word-aligned fetch words into 16/32-bit instructions,
// tracking the PC and stitching 32-bit instructions that straddle two fetch words.
module ibex_instr_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    input  logic        fetch_err_i,
    output logic        fetch_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic        out_is_compressed_o,
    output logic        out_err_o
);

    typedef enum logic [1:0] {EMPTY, BUF, HALT} state_e;

    state_e      state_reg, state_next;
    logic [31:1] pc_reg, pc_next;
    logic [15:0] buf_hw_reg, buf_hw_next;
    logic        lo_is_compressed;
    logic        hi_is_compressed;
    logic        unused_flush_lsb;

    assign lo_is_compressed = fetch_rdata_i[1:0] != 2'b11;
    assign hi_is_compressed = fetch_rdata_i[17:16] != 2'b11;
    assign unused_flush_lsb = flush_addr_i[0];

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        buf_hw_next   = buf_hw_reg;
        out_valid_o   = 1'b0;
        out_err_o     = 1'b0;
        out_instr_o   = '0;
        fetch_ready_o = 1'b0;

        // Outputs are gated by rst so an in-flight instruction drops at once.
        if (rst) begin
            state_next = EMPTY;
        end else if (flush_i) begin
            fetch_ready_o = 1'b1;
            pc_next       = flush_addr_i[31:1];
            state_next    = EMPTY;
        end else if (state_reg == HALT) begin
            fetch_ready_o = 1'b1;
        end else if (fetch_valid_i) begin
            if (fetch_err_i) begin
                out_valid_o   = 1'b1;
                out_err_o     = 1'b1;
                fetch_ready_o = out_ready_i;
                if (out_ready_i) begin
                    state_next = HALT;
                end
            end else if (state_reg == BUF) begin
                // Upper half of this word starts the next instruction, so keep it.
                out_valid_o = 1'b1;
                out_instr_o = {fetch_rdata_i[15:0], buf_hw_reg};
                if (out_ready_i) begin
                    pc_next    = pc_reg + 31'd2;
                    state_next = EMPTY;
                end
            end else if (!pc_reg[1]) begin
                out_valid_o = 1'b1;
                if (lo_is_compressed) begin
                    out_instr_o = {16'h0000, fetch_rdata_i[15:0]};
                    if (out_ready_i) begin
                        pc_next = pc_reg + 31'd1;
                    end
                end else begin
                    out_instr_o   = fetch_rdata_i;
                    fetch_ready_o = out_ready_i;
                    if (out_ready_i) begin
                        pc_next = pc_reg + 31'd2;
                    end
                end
            end else if (hi_is_compressed) begin
                out_valid_o   = 1'b1;
                out_instr_o   = {16'h0000, fetch_rdata_i[31:16]};
                fetch_ready_o = out_ready_i;
                if (out_ready_i) begin
                    pc_next = pc_reg + 31'd1;
                end
            end else begin
                fetch_ready_o = 1'b1;
                buf_hw_next   = fetch_rdata_i[31:16];
                state_next    = BUF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= EMPTY;
            pc_reg     <= BOOT_ADDR[31:1];
            buf_hw_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            buf_hw_reg <= buf_hw_next;
        end
    end

    assign out_pc_o            = {pc_reg, 1'b0};
    assign out_is_compressed_o = out_instr_o[1:0] != 2'b11;

endmodule

// File: tb/tb_ibex_instr_aligner.sv
// Bench for ibex_instr_aligner: directed vector table, async-reset sequence, and random
// fetch streams compared against a halfword-stream instruction parser.
module tb_ibex_instr_aligner;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [31:0] flush_addr_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_err_i;
    logic        fetch_ready_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_is_compressed_o;
    logic        out_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    ibex_instr_aligner #(.BOOT_ADDR(32'h0000_0080)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush_i             (flush_i),
        .flush_addr_i        (flush_addr_i),
        .fetch_valid_i       (fetch_valid_i),
        .fetch_rdata_i       (fetch_rdata_i),
        .fetch_err_i         (fetch_err_i),
        .fetch_ready_o       (fetch_ready_o),
        .out_valid_o         (out_valid_o),
        .out_ready_i         (out_ready_i),
        .out_instr_o         (out_instr_o),
        .out_pc_o            (out_pc_o),
        .out_is_compressed_o (out_is_compressed_o),
        .out_err_o           (out_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [31:0] faddr;
        logic        fv;
        logic [31:0] w;
        logic        ferr;
        logic        ordy;
        logic        e_valid;
        logic        e_fready;
        logic        e_err;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        int          ck;      // 0: control only, 1: + pc, 2: + pc/instr/compressed
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic fl, input logic [31:0] fa,
                       input logic fv, input logic [31:0] w, input logic fe, input logic ordy,
                       input logic ev, input logic efr, input logic eerr,
                       input logic [31:0] ei, input logic [31:0] ep, input int ck);
        vec_t v;
        v.rst = r; v.flush = fl; v.faddr = fa; v.fv = fv; v.w = w; v.ferr = fe; v.ordy = ordy;
        v.e_valid = ev; v.e_fready = efr; v.e_err = eerr; v.e_instr = ei; v.e_pc = ep; v.ck = ck;
        vecs.push_back(v);
    endtask

    // Random-stream reference: a halfword memory based at 0x80, parsed into instructions.
    localparam int NHW = 256;
    localparam logic [31:0] BASE = 32'h0000_0080;
    logic [15:0] hw_mem[NHW];
    logic [31:0] exp_pc[$];
    logic [31:0] exp_instr[$];

    function automatic logic [31:0] mem_word(input int wi);
        if (wi >= NHW / 2) return 32'h0;
        return {hw_mem[2*wi+1], hw_mem[2*wi]};
    endfunction

    task automatic build_program(input logic [31:0] start);
        logic [31:0] a;
        int h;
        logic [31:0] r;
        for (int i = 0; i < NHW; i++) begin
            r = $urandom;
            hw_mem[i] = (r[16]) ? {r[15:2], 2'b11} : {r[15:2], r[1] ? 2'b10 : 2'b01};
        end
        exp_pc.delete();
        exp_instr.delete();
        a = start;
        h = int'((a - BASE) >> 1);
        while (h < NHW - 16) begin
            exp_pc.push_back(a);
            if (hw_mem[h][1:0] != 2'b11) begin
                exp_instr.push_back({16'h0000, hw_mem[h]});
                a = a + 32'd2;
            end else begin
                exp_instr.push_back({hw_mem[h+1], hw_mem[h]});
                a = a + 32'd4;
            end
            h = int'((a - BASE) >> 1);
        end
    endtask

    task automatic run_random(input logic [31:0] start, input bit do_flush);
        int wi, n, nexp;
        bit pending, prev_stall, acc;
        logic [31:0] prev_instr, prev_pc;
        build_program(start);
        nexp = exp_pc.size();
        if (do_flush) begin
            flush_i = 1'b1; flush_addr_i = start; fetch_valid_i = 1'b0; out_ready_i = 1'b1;
            @(posedge clk); #1;
            flush_i = 1'b0;
        end
        wi = 0; n = 0; pending = 0; prev_stall = 0; prev_instr = 0; prev_pc = 0;
        for (int cyc = 0; cyc < 4000 && n < nexp; cyc++) begin
            if (!pending) fetch_valid_i = ($urandom % 4) != 0;
            fetch_rdata_i = fetch_valid_i ? mem_word(wi) : $urandom;
            fetch_err_i   = 1'b0;
            out_ready_i   = ($urandom % 3) != 0;
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_valid", n, {31'd0, out_valid_o}, 32'd1);
                chk("stall_instr", n, out_instr_o, prev_instr);
                chk("stall_pc", n, out_pc_o, prev_pc);
            end
            if (out_valid_o && out_ready_i) begin
                chk("rnd_pc", n, out_pc_o, exp_pc[n]);
                chk("rnd_instr", n, out_instr_o, exp_instr[n]);
                chk("rnd_cmp", n, {31'd0, out_is_compressed_o}, {31'd0, exp_instr[n][1:0] != 2'b11});
                n++;
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_instr = out_instr_o;
            prev_pc    = out_pc_o;
            acc     = fetch_valid_i && fetch_ready_o;
            pending = fetch_valid_i && !fetch_ready_o;
            @(posedge clk); #1;
            if (acc) wi++;
        end
        chk("rnd_count", 0, n, nexp);
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; flush_addr_i = '0; fetch_valid_i = 1'b0;
        fetch_rdata_i = '0; fetch_err_i = 1'b0; out_ready_i = 1'b0;

        // reset, then aligned 32-bit
        add(1, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 32'h80, 1);
        add(0, 0, 0, 1, 32'h0000_0013, 0, 1,          1, 1, 0, 32'h13, 32'h80, 2);
        // two compressed in one word
        add(0, 1, 32'h80, 0, 0, 0, 1,                 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 32'h4505_4501, 0, 1,          1, 0, 0, 32'h4501, 32'h80, 2);
        add(0, 0, 0, 1, 32'h4505_4501, 0, 1,          1, 1, 0, 32'h4505, 32'h82, 2);
        // straddle with backpressure in BUF
        add(0, 1, 32'h80, 0, 0, 0, 1,                 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 32'h0093_4501, 0, 1,          1, 0, 0, 32'h4501, 32'h80, 2);
        add(0, 0, 0, 1, 32'h0093_4501, 0, 1,          0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 1, 32'h4505_0000, 0, 0,      1, 0, 0, 32'h93, 32'h82, 2);
        add(0, 0, 0, 1, 32'h4505_0000, 0, 1,          1, 0, 0, 32'h93, 32'h82, 2);
        add(0, 0, 0, 1, 32'h4505_0000, 0, 1,          1, 1, 0, 32'h4505, 32'h86, 2);
        add(0, 0, 0, 0, 0, 0, 1,                      0, 0, 0, 0, 32'h88, 1);
        // flush to odd halfword, word presented during flush is discarded
        add(0, 1, 32'h102, 1, 32'hdead_beef, 0, 1,    0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 32'h4505_0013, 0, 1,          1, 1, 0, 32'h4505, 32'h102, 2);
        // error on second word of a straddle, drain, then flush
        add(0, 1, 32'h80, 0, 0, 0, 1,                 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 32'h0093_4501, 0, 1,          1, 0, 0, 32'h4501, 32'h80, 2);
        add(0, 0, 0, 1, 32'h0093_4501, 0, 1,          0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 32'h4505_0000, 1, 1,          1, 1, 1, 32'h0, 32'h82, 2);
        add(0, 0, 0, 1, 32'h1234_5678, 0, 1,          0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 32'h0000_0000, 0, 1,          0, 1, 0, 0, 0, 0);
        add(0, 1, 32'h200, 1, 32'h1111_1111, 0, 1,    0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 32'h0000_0013, 0, 1,          1, 1, 0, 32'h13, 32'h200, 2);
        // PC wrap
        add(0, 1, 32'hffff_fffe, 0, 0, 0, 1,          0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 32'h4501_0000, 0, 1,          1, 1, 0, 32'h4501, 32'hffff_fffe, 2);
        add(0, 0, 0, 1, 32'h0000_0013, 0, 1,          1, 1, 0, 32'h13, 32'h0, 2);
        // enter BUF and stall there, for the async reset sequence below
        add(0, 1, 32'h202, 0, 0, 0, 1,                0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 32'h0013_0000, 0, 1,          0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 32'h0000_0000, 0, 0,          1, 0, 0, 32'h13, 32'h202, 2);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; flush_i = vecs[i].flush; flush_addr_i = vecs[i].faddr;
            fetch_valid_i = vecs[i].fv; fetch_rdata_i = vecs[i].w;
            fetch_err_i = vecs[i].ferr; out_ready_i = vecs[i].ordy;
            @(negedge clk);
            chk("valid", i, {31'd0, out_valid_o}, {31'd0, vecs[i].e_valid});
            chk("fetch_ready", i, {31'd0, fetch_ready_o}, {31'd0, vecs[i].e_fready});
            chk("err", i, {31'd0, out_err_o}, {31'd0, vecs[i].e_err});
            if (vecs[i].ck >= 1) chk("pc", i, out_pc_o, vecs[i].e_pc);
            if (vecs[i].ck >= 2) begin
                chk("instr", i, out_instr_o, vecs[i].e_instr);
                chk("compressed", i, {31'd0, out_is_compressed_o},
                    {31'd0, vecs[i].e_instr[1:0] != 2'b11});
            end
            @(posedge clk); #1;
        end

        // async reset mid-BUF: valid must fall before any clock edge
        #2;
        chk("buf_hold_valid", 0, {31'd0, out_valid_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 0, {31'd0, out_valid_o}, 32'd0);
        chk("async_rst_fready", 0, {31'd0, fetch_ready_o}, 32'd0);
        chk("async_rst_pc", 0, out_pc_o, 32'h80);
        @(posedge clk); #1;
        rst = 1'b0; fetch_valid_i = 1'b0; out_ready_i = 1'b0;

        run_random(32'h80, 1'b0);
        run_random(32'h82, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
